// File: rtl/simon_seq_engine.sv
// Simon game sequencer: appends a random step per round, plays the stored sequence
// back, times and checks player entry, and reports score, win and loss.
module simon_seq_engine #(
    parameter int NUM_BTNS = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_LEN  = 32,
    parameter int SCORE_W  = 8,
    parameter int TONE_ON  = 37500000,
    parameter int TONE_GAP = 12500000,
    parameter int TIMEOUT  = 150000000,
    parameter int TMR_W    = 28
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_BTNS-1:0] btn_press,
    input  logic [IDX_W-1:0]    rand_idx,
    output logic [IDX_W-1:0]    lamp_idx,
    output logic                lamp_en,
    output logic                tone_en,
    output logic [SCORE_W-1:0]  score,
    output logic                busy,
    output logic                win,
    output logic                game_over,
    output logic [3:0]          state_dbg
);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        APPEND   = 4'd1,
        PLAY_ON  = 4'd2,
        PLAY_GAP = 4'd3,
        WAIT_IN  = 4'd4,
        ECHO     = 4'd5,
        CHECK    = 4'd6,
        WIN      = 4'd7,
        LOSE     = 4'd8
    } state_t;

    state_t             state;
    logic [SCORE_W-1:0] len;
    logic [ADDR_W-1:0]  pos;
    logic [TMR_W-1:0]   timer;
    logic [IDX_W-1:0]   key;
    logic               multi;
    logic [IDX_W-1:0]   seq [2**ADDR_W];

    logic               on_done;
    logic               gap_done;
    logic               wait_done;
    logic               last_step;
    logic [IDX_W-1:0]   folded_idx;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_BTNS-1:0] b);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (b[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign on_done   = (timer == TMR_W'(TONE_ON - 1));
    assign gap_done  = (timer == TMR_W'(TONE_GAP - 1));
    assign wait_done = (timer == TMR_W'(TIMEOUT - 1));
    assign last_step = (SCORE_W'(pos) == len - SCORE_W'(1));

    // The PRNG may produce indices past the last button; fold them back into range.
    assign folded_idx = ({1'b0, rand_idx} >= (IDX_W + 1)'(NUM_BTNS))
                      ? rand_idx - IDX_W'(NUM_BTNS) : rand_idx;

    // Sequence memory survives reset so it carries no reset term.
    always_ff @(posedge clk) begin
        if (state == APPEND) seq[len[ADDR_W-1:0]] <= folded_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            len   <= '0;
            pos   <= '0;
            timer <= '0;
            score <= '0;
            key   <= '0;
            multi <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        len   <= '0;
                        score <= '0;
                        state <= APPEND;
                    end
                end
                APPEND: begin
                    len   <= len + SCORE_W'(1);
                    pos   <= '0;
                    timer <= '0;
                    state <= PLAY_ON;
                end
                PLAY_ON: begin
                    if (on_done) begin
                        timer <= '0;
                        state <= PLAY_GAP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                PLAY_GAP: begin
                    if (gap_done) begin
                        timer <= '0;
                        if (last_step) begin
                            pos   <= '0;
                            state <= WAIT_IN;
                        end else begin
                            pos   <= pos + ADDR_W'(1);
                            state <= PLAY_ON;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                WAIT_IN: begin
                    // A press coinciding with the timeout is still honoured.
                    if (|btn_press) begin
                        key   <= lowest_set(btn_press);
                        multi <= |(btn_press & (btn_press - NUM_BTNS'(1)));
                        timer <= '0;
                        state <= ECHO;
                    end else if (wait_done) begin
                        timer <= '0;
                        state <= LOSE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ECHO: begin
                    if (on_done) begin
                        timer <= '0;
                        state <= CHECK;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                CHECK: begin
                    if (multi || key != seq[pos]) begin
                        state <= LOSE;
                    end else if (!last_step) begin
                        pos   <= pos + ADDR_W'(1);
                        timer <= '0;
                        state <= WAIT_IN;
                    end else begin
                        score <= len;
                        state <= (len == SCORE_W'(MAX_LEN)) ? WIN : APPEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lamp_en   = (state == PLAY_ON) || (state == ECHO);
    assign tone_en   = lamp_en;
    assign lamp_idx  = (state == PLAY_ON) ? seq[pos] : ((state == ECHO) ? key : '0);
    assign busy      = !((state == IDLE) || (state == WIN) || (state == LOSE));
    assign win       = (state == WIN);
    assign game_over = (state == LOSE);
    assign state_dbg = state;
endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine with short tone/timeout counts and a 3-step game.
module tb_simon_seq_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn_press = '0;
    logic [1:0] rand_idx = '0;
    logic [1:0] lamp_idx;
    logic       lamp_en, tone_en, busy, win, game_over;
    logic [7:0] score;
    logic [3:0] state_dbg;

    logic       b_start = 1'b0;
    logic [4:0] b_btn = '0;
    logic [2:0] b_rand = '0;
    logic [2:0] b_lamp_idx;
    logic       b_lamp_en, b_tone_en, b_busy, b_win, b_game_over;
    logic [7:0] b_score;
    logic [3:0] b_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    simon_seq_engine #(
        .NUM_BTNS(4), .IDX_W(2), .MAX_LEN(3), .SCORE_W(8),
        .TONE_ON(4), .TONE_GAP(2), .TIMEOUT(20), .TMR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn_press(btn_press),
        .rand_idx(rand_idx), .lamp_idx(lamp_idx), .lamp_en(lamp_en),
        .tone_en(tone_en), .score(score), .busy(busy), .win(win),
        .game_over(game_over), .state_dbg(state_dbg)
    );

    simon_seq_engine #(
        .NUM_BTNS(5), .IDX_W(3), .MAX_LEN(3), .SCORE_W(8),
        .TONE_ON(4), .TONE_GAP(2), .TIMEOUT(20), .TMR_W(8)
    ) dut5 (
        .clk(clk), .reset(reset), .start(b_start), .btn_press(b_btn),
        .rand_idx(b_rand), .lamp_idx(b_lamp_idx), .lamp_en(b_lamp_en),
        .tone_en(b_tone_en), .score(b_score), .busy(b_busy), .win(b_win),
        .game_over(b_game_over), .state_dbg(b_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_lit(input string tag, input logic [1:0] idx);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_en"}, 32'(lamp_en), 1);
            check({tag, "_tone"}, 32'(tone_en), 1);
            check({tag, "_idx"}, 32'(lamp_idx), 32'(idx));
            step();
        end
    endtask

    task automatic expect_play(input logic [1:0] idx);
        check("play_state", 32'(state_dbg), 2);
        expect_lit("play", idx);
        for (int i = 0; i < 2; i++) begin
            check("gap_state", 32'(state_dbg), 3);
            check("gap_en", 32'(lamp_en), 0);
            check("gap_tone", 32'(tone_en), 0);
            step();
        end
    endtask

    task automatic press(input logic [3:0] b, input logic [1:0] idx);
        btn_press = b;
        step();
        btn_press = '0;
        check("echo_state", 32'(state_dbg), 5);
        expect_lit("echo", idx);
        check("check_state", 32'(state_dbg), 6);
        step();
    endtask

    task automatic begin_game();
        start = 1'b1;
        rand_idx = 2'd2;
        step();
        start = 1'b0;
        check("append_state", 32'(state_dbg), 1);
        check("append_busy", 32'(busy), 1);
        step();
        expect_play(2'd2);
        check("wait_state", 32'(state_dbg), 4);
    endtask

    initial begin
        step();
        check("rst_state", 32'(state_dbg), 0);
        check("rst_lamp", 32'(lamp_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_score", 32'(score), 0);
        reset = 1'b1;
        step();

        // Five-button instance folds an out-of-range random value.
        b_start = 1'b1;
        b_rand = 3'd6;
        step();
        b_start = 1'b0;
        step();
        check("fold_en", 32'(b_lamp_en), 1);
        check("fold_idx", 32'(b_lamp_idx), 1);

        // Full winning game: sequence 2,1,3.
        begin_game();
        check("r1_score", 32'(score), 0);
        rand_idx = 2'd1;
        press(4'b0100, 2'd2);
        check("r1_append", 32'(state_dbg), 1);
        check("r1_score_done", 32'(score), 1);
        step();
        expect_play(2'd2);
        expect_play(2'd1);
        press(4'b0100, 2'd2);
        check("r2_mid_wait", 32'(state_dbg), 4);
        press(4'b0010, 2'd1);
        check("r2_score", 32'(score), 2);
        rand_idx = 2'd3;
        step();
        expect_play(2'd2);
        expect_play(2'd1);
        expect_play(2'd3);
        press(4'b0100, 2'd2);
        press(4'b0010, 2'd1);
        press(4'b1000, 2'd3);
        check("win_state", 32'(state_dbg), 7);
        check("win_flag", 32'(win), 1);
        check("win_busy", 32'(busy), 0);
        check("win_score", 32'(score), 3);
        btn_press = 4'b0001;
        step();
        btn_press = '0;
        check("win_ignore_btn", 32'(state_dbg), 7);

        // Restart, then lose on a wrong entry in round 2.
        begin_game();
        check("restart_score", 32'(score), 0);
        check("restart_win", 32'(win), 0);
        rand_idx = 2'd0;
        press(4'b0100, 2'd2);
        check("g2_score", 32'(score), 1);
        step();
        expect_play(2'd2);
        expect_play(2'd0);
        press(4'b0001, 2'd0);
        check("wrong_state", 32'(state_dbg), 8);
        check("wrong_over", 32'(game_over), 1);
        check("wrong_score", 32'(score), 1);
        check("wrong_busy", 32'(busy), 0);

        // Timeout with a stray start pulse that must be ignored.
        begin_game();
        for (int i = 0; i < 19; i++) begin
            if (i == 5) start = 1'b1;
            step();
            start = 1'b0;
        end
        check("to_last_cycle", 32'(state_dbg), 4);
        step();
        check("to_state", 32'(state_dbg), 8);
        check("to_over", 32'(game_over), 1);

        // Press on the final allowed cycle is accepted.
        begin_game();
        for (int i = 0; i < 19; i++) step();
        check("late_wait", 32'(state_dbg), 4);
        rand_idx = 2'd3;
        press(4'b0100, 2'd2);
        check("late_append", 32'(state_dbg), 1);
        check("late_score", 32'(score), 1);

        // Asynchronous reset in the middle of playback.
        step();
        step();
        step();
        check("pre_rst_lit", 32'(lamp_en), 1);
        reset = 1'b0;
        #1;
        check("arst_state", 32'(state_dbg), 0);
        check("arst_lamp", 32'(lamp_en), 0);
        check("arst_tone", 32'(tone_en), 0);
        check("arst_idx", 32'(lamp_idx), 0);
        check("arst_score", 32'(score), 0);
        check("arst_busy", 32'(busy), 0);
        reset = 1'b1;
        step();

        // Two buttons at once: echo shows the lowest, then the game is lost.
        begin_game();
        btn_press = 4'b0110;
        step();
        btn_press = '0;
        check("multi_echo", 32'(state_dbg), 5);
        expect_lit("multi", 2'd1);
        check("multi_check", 32'(state_dbg), 6);
        step();
        check("multi_lose", 32'(state_dbg), 8);
        check("multi_over", 32'(game_over), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
